// File: rtl/cmp_iter.sv
// Iterative WIDTH-bit magnitude comparator: walks CHUNK-bit slices from the MSB end and stops
// at the first differing slice. Signed mode is mapped onto unsigned by flipping both sign bits.
module cmp_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned CW = $clog2(NCHUNK + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             GT,
  output logic             LT,
  output logic             EQ,
  output logic [CW-1:0]    CHUNKS_USED
);

  localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("cmp_iter: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    used_q, used_d;
  logic             valid_q, valid_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CHUNK-1:0] chunk_a, chunk_b;

  assign chunk_a = CHUNK'(a_q >> (idx_q * CHUNK));
  assign chunk_b = CHUNK'(b_q >> (idx_q * CHUNK));

  assign IN_READY    = (state_q == StIdle) && !RST;
  assign OUT_VALID   = valid_q;
  assign GT          = gt_q;
  assign LT          = lt_q;
  assign EQ          = eq_q;
  assign CHUNKS_USED = used_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    valid_d = valid_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID && IN_READY) begin
          a_d = A;
          b_d = B;
          // Flipping the sign bit turns two's-complement order into unsigned order.
          if (SIGNED) begin
            a_d[WIDTH-1] = ~A[WIDTH-1];
            b_d[WIDTH-1] = ~B[WIDTH-1];
          end
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = CW'(1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (chunk_a != chunk_b || idx_q == '0) begin
          gt_d    = chunk_a > chunk_b;
          lt_d    = chunk_a < chunk_b;
          eq_d    = chunk_a == chunk_b;
          used_d  = cnt_q;
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IW'(1);
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (OUT_READY) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      used_q  <= '0;
      valid_q <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      used_q  <= used_d;
      valid_q <= valid_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

endmodule
